wave_period_meter: RTL
======================

Name: wave_period_meter

Overview:
- Downstream consumer of the waveform generator output (wave_o). Watches the signed sample stream and detects peaks with a direction-tracking FSM that has hysteresis.
- Reports, in clock cycles, the period between consecutive peaks, plus the max and min sample values seen in that period.
- In-silicon counterpart to the bench's frequency check; feeds status registers and self-test logic.

Parameters:
- DATA_WIDTH, 8, width of signed input sample; matches the generator output width.
- CNT_WIDTH, 16, width of the period counter and of period_o.
- HYST, 0, unsigned hysteresis in LSBs; range 0 to 2**(DATA_WIDTH-1)-1.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  reset, synchronous, active-high.
- sample_i  in  DATA_WIDTH  signed sample (connects to wave_o).
- sample_valid_i  in  1  sample_i is accepted on clk rising edge when high.
- clear_i  in  1  synchronous soft clear; same effect as rst on internal state, outputs held.
- period_o  out  CNT_WIDTH  clock cycles between the last two peak events.
- peak_o  out  DATA_WIDTH  signed max sample in the last measured period.
- valley_o  out  DATA_WIDTH  signed min sample in the last measured period.
- meas_valid_o  out  1  one-cycle pulse when period_o/peak_o/valley_o update.
- timeout_o  out  1  sticky; period counter saturated since the last clear.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- rst: all outputs 0. FSM to UNKNOWN. Counter 0. Armed flag 0. Running max/min and ref cleared.
- clear_i: resets FSM, counter, armed flag, running max/min and timeout_o. period_o, peak_o and valley_o keep their values. meas_valid_o is 0 that cycle. rst has priority over clear_i.
- All compares use DATA_WIDTH+1 signed arithmetic (ref±HYST never wraps).
- FSM states and transitions, evaluated only on accepted samples:
  - UNKNOWN: the first sample loads ref. After that:
    - sample > ref+HYST: go to RISING, ref=sample.
    - sample < ref-HYST: go to FALLING, ref=sample.
  - RISING: sample > ref: ref=sample. sample < ref-HYST: PEAK EVENT, go to FALLING, ref=sample.
  - FALLING: sample < ref: ref=sample. sample > ref+HYST: go to RISING, ref=sample.
  - Equal samples and moves within the hysteresis band never change state (plateaus ignored).
- Period counter:
  - Increments every clk while armed, independent of sample_valid_i.
  - Saturates at 2**CNT_WIDTH-1 and sets timeout_o.
- Peak event handling:
  - If not armed: set armed, counter=0, running max/min = event sample. No output.
  - If armed and counter not saturated: period_o=counter+1, peak_o=max, valley_o=min, where max/min include the event sample. meas_valid_o=1 in the next cycle. Then counter=0 and max/min reload with the event sample.
  - If armed and counter saturated: no meas_valid_o, outputs unchanged, counter=0, window restarts, timeout_o stays 1.
- Running max/min update on every accepted sample while armed.
- Latency: the event sample accepted at edge N gives meas_valid_o and new outputs visible after edge N+1 (one register stage). No backpressure; meas_valid_o is a single-cycle pulse.
- Rectangular input: the high-to-low step is the peak event; the low-to-high step only enters RISING.
- Sawtooth input: one event per reset of the ramp.

Optional Feature:
- Macro WAVE_PERIOD_METER_AVG_EN.
- When defined: an accumulator of CNT_WIDTH+2 bits sums 4 consecutive valid periods.
  - Every 4th valid measurement: period_o = sum>>2 (truncated), and meas_valid_o pulses.
  - peak_o/valley_o report the max/min over the 4 windows.
  - A saturated (timeout) window, clear_i or rst restarts the group of 4.
- When undefined: the accumulator is absent and every valid measurement is reported.

Test Plan:
- Triangle stimulus:
  - Stimulus: HYST=0, valid always 1. Triangle 0,1..8,7..-8,-7..0 repeating; period 32 samples.
  - Required: first event arms only; from the 2nd event on, meas_valid_o every 32 clocks, period_o=32, peak_o=8, valley_o=-8.
- Rectangular stimulus:
  - Stimulus: +100 for 10 cycles, -100 for 10 cycles, repeating.
  - Required: period_o=20, peak_o=100, valley_o=-100, one pulse per 20 cycles.
- Valid gaps:
  - Stimulus: the triangle above, with sample_valid_i low every other cycle (each sample held 2 clocks).
  - Required: period_o=64; a sample held while valid is low has no effect.
- Hysteresis:
  - Stimulus: HYST=2, input 0/±1 jitter for 200 cycles.
  - Required: no meas_valid_o, FSM stays UNKNOWN or at a single direction.
  - Stimulus: then a ±50 square with period 40.
  - Required: period_o=40.
- Timeout:
  - Stimulus: CNT_WIDTH=6; square with period 100 (events 100 cycles apart, >63).
  - Required: timeout_o=1, no meas_valid_o.
  - Stimulus: clear_i, then a square with period 40.
  - Required: timeout_o=0, period_o=40 from the 2nd event after the clear.
- Reset and clear mid-measurement:
  - Stimulus: rst asserted mid-period while armed.
  - Required: all outputs 0 next cycle; first event after the release arms only.
  - Stimulus: clear_i at the same point instead.
  - Required: period_o/peak_o/valley_o retained.
  - With WAVE_PERIOD_METER_AVG_EN: periods 30,30,34,34 give period_o=32 on the 4th pulse only.

Source files
------------

// File: rtl/wave_period_meter.sv
// Peak-to-peak period meter for a signed sample stream, with hysteresis on direction changes.
// Optional WAVE_PERIOD_METER_AVG_EN averages each group of 4 valid periods before reporting.
module wave_period_meter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int HYST       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] sample_i,
    input  logic                         sample_valid_i,
    input  logic                         clear_i,
    output logic [CNT_WIDTH-1:0]         period_o,
    output logic signed [DATA_WIDTH-1:0] peak_o,
    output logic signed [DATA_WIDTH-1:0] valley_o,
    output logic                         meas_valid_o,
    output logic                         timeout_o
);
    localparam int W1 = DATA_WIDTH + 1;
    localparam logic signed [W1-1:0] HYST_X = W1'(HYST);

    typedef enum logic [1:0] {S_UNKNOWN, S_RISING, S_FALLING} state_t;

    state_t                        state_q, state_d;
    logic                          have_ref_q, have_ref_d;
    logic signed [DATA_WIDTH-1:0]  ref_q, ref_d;
    logic                          peak_evt;

    logic signed [W1-1:0] smp_x, ref_x, ref_hi, ref_lo;
    assign smp_x  = {sample_i[DATA_WIDTH-1], sample_i};
    assign ref_x  = {ref_q[DATA_WIDTH-1], ref_q};
    assign ref_hi = ref_x + HYST_X;
    assign ref_lo = ref_x - HYST_X;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state_q    <= S_UNKNOWN;
            have_ref_q <= 1'b0;
            ref_q      <= '0;
        end else begin
            state_q    <= state_d;
            have_ref_q <= have_ref_d;
            ref_q      <= ref_d;
        end
    end

    // Plateaus and moves inside the band leave state and ref untouched.
    always_comb begin
        state_d    = state_q;
        have_ref_d = have_ref_q;
        ref_d      = ref_q;
        peak_evt   = 1'b0;
        if (sample_valid_i) begin
            case (state_q)
                S_UNKNOWN: begin
                    if (!have_ref_q) begin
                        have_ref_d = 1'b1;
                        ref_d      = sample_i;
                    end else if (smp_x > ref_hi) begin
                        state_d = S_RISING;
                        ref_d   = sample_i;
                    end else if (smp_x < ref_lo) begin
                        state_d = S_FALLING;
                        ref_d   = sample_i;
                    end
                end
                S_RISING: begin
                    if (smp_x > ref_x) begin
                        ref_d = sample_i;
                    end else if (smp_x < ref_lo) begin
                        peak_evt = 1'b1;
                        state_d  = S_FALLING;
                        ref_d    = sample_i;
                    end
                end
                S_FALLING: begin
                    if (smp_x < ref_x) begin
                        ref_d = sample_i;
                    end else if (smp_x > ref_hi) begin
                        state_d = S_RISING;
                        ref_d   = sample_i;
                    end
                end
                default: state_d = S_UNKNOWN;
            endcase
        end
    end

    logic                         armed_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic signed [DATA_WIDTH-1:0] run_max_q, run_min_q;
    logic                         cnt_sat, meas_ok;
    logic [CNT_WIDTH-1:0]         meas_period;
    logic signed [DATA_WIDTH-1:0] evt_max, evt_min;

    assign cnt_sat     = (cnt_q == {CNT_WIDTH{1'b1}});
    assign meas_ok     = peak_evt && armed_q && !cnt_sat;
    assign meas_period = cnt_q + CNT_WIDTH'(1);
    assign evt_max     = (sample_i > run_max_q) ? sample_i : run_max_q;
    assign evt_min     = (sample_i < run_min_q) ? sample_i : run_min_q;

    logic                         rep_fire;
    logic [CNT_WIDTH-1:0]         rep_period;
    logic signed [DATA_WIDTH-1:0] rep_peak, rep_valley;

`ifdef WAVE_PERIOD_METER_AVG_EN
    logic [CNT_WIDTH+1:0]         acc_q, acc_n;
    logic [1:0]                   grp_q;
    logic signed [DATA_WIDTH-1:0] gmax_q, gmin_q, gmax_n, gmin_n;

    assign acc_n      = ((grp_q == 2'd0) ? '0 : acc_q) + (CNT_WIDTH+2)'(meas_period);
    assign gmax_n     = (grp_q == 2'd0 || evt_max > gmax_q) ? evt_max : gmax_q;
    assign gmin_n     = (grp_q == 2'd0 || evt_min < gmin_q) ? evt_min : gmin_q;
    assign rep_fire   = meas_ok && (grp_q == 2'd3);
    assign rep_period = CNT_WIDTH'(acc_n >> 2);
    assign rep_peak   = gmax_n;
    assign rep_valley = gmin_n;

    // A timed-out window breaks the group; the next valid period starts a new one.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            acc_q  <= '0;
            grp_q  <= 2'd0;
            gmax_q <= '0;
            gmin_q <= '0;
        end else if (meas_ok) begin
            acc_q  <= acc_n;
            grp_q  <= grp_q + 2'd1;
            gmax_q <= gmax_n;
            gmin_q <= gmin_n;
        end else if (peak_evt && armed_q) begin
            grp_q <= 2'd0;
        end
    end
`else
    assign rep_fire   = meas_ok;
    assign rep_period = meas_period;
    assign rep_peak   = evt_max;
    assign rep_valley = evt_min;
`endif

    logic                         pend_vld_q;
    logic [CNT_WIDTH-1:0]         pend_period_q;
    logic signed [DATA_WIDTH-1:0] pend_peak_q, pend_valley_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            run_max_q     <= '0;
            run_min_q     <= '0;
            timeout_o     <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_period_q <= '0;
            pend_peak_q   <= '0;
            pend_valley_q <= '0;
            meas_valid_o  <= 1'b0;
            period_o      <= '0;
            peak_o        <= '0;
            valley_o      <= '0;
        end else if (clear_i) begin
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            run_max_q    <= '0;
            run_min_q    <= '0;
            timeout_o    <= 1'b0;
            pend_vld_q   <= 1'b0;
            meas_valid_o <= 1'b0;
        end else begin
            meas_valid_o <= pend_vld_q;
            if (pend_vld_q) begin
                period_o <= pend_period_q;
                peak_o   <= pend_peak_q;
                valley_o <= pend_valley_q;
            end
            pend_vld_q <= 1'b0;
            if (armed_q) begin
                if (cnt_sat) timeout_o <= 1'b1;
                else         cnt_q     <= cnt_q + CNT_WIDTH'(1);
                if (sample_valid_i) begin
                    run_max_q <= evt_max;
                    run_min_q <= evt_min;
                end
            end
            if (peak_evt) begin
                armed_q   <= 1'b1;
                cnt_q     <= '0;
                run_max_q <= sample_i;
                run_min_q <= sample_i;
                if (rep_fire) begin
                    pend_vld_q    <= 1'b1;
                    pend_period_q <= rep_period;
                    pend_peak_q   <= rep_peak;
                    pend_valley_q <= rep_valley;
                end
            end
        end
    end
endmodule
